// File: rtl/serial_shifter_pkg.sv
// Shared types and constants for the multi-cycle serial shift/rotate unit.
package serial_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;
    localparam logic MODE_LOGICAL = 1'b0;
    localparam logic MODE_ROTATE  = 1'b1;

endpackage

// File: rtl/serial_shifter_if.sv
// Start/busy/done request bus of the serial shifter; master issues operations.
interface serial_shifter_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [AMT_W-1:0] amt;
    logic             dir;
    logic             rotate;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output start, A, amt, dir, rotate,
        input  busy, done, out
    );

    modport slave (
        input  start, A, amt, dir, rotate,
        output busy, done, out
    );
endinterface

// File: rtl/serial_shifter_shift_step.sv
// Combinational single-position shift: logical or rotate, left or right.
module shift_step
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    input  logic             rotate,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        // NOTE: default assignment first so no path leaves 'shifted' unassigned (no latch).
        shifted = word;
        if (dir == DIR_LEFT) begin
            shifted = {word[WIDTH-2:0], (rotate == MODE_ROTATE) ? word[WIDTH-1] : 1'b0};
        end else begin
            shifted = {(rotate == MODE_ROTATE) ? word[0] : 1'b0, word[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: moves the captured word one bit per clock, then pulses done.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_shifter_if.slave   bus
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [AMT_W-1:0] count;
    logic             dir_q;
    logic             rotate_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .word    (work),
        .dir     (dir_q),
        .rotate  (rotate_q),
        .shifted (work_next)
    );

    // Amounts >= WIDTH need no special case: logical shifts drain to zero and
    // rotations wrap naturally while the counter runs down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a plain flop, so all of them are reset.
            state    <= IDLE;
            work     <= '0;
            count    <= '0;
            dir_q    <= DIR_LEFT;
            rotate_q <= MODE_LOGICAL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work     <= bus.A;
                        count    <= bus.amt;
                        dir_q    <= bus.dir;
                        rotate_q <= bus.rotate;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count == '0) begin
                        out_q  <= work;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        work  <= work_next;
                        count <= count - AMT_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule
